// File: rtl/divider_pkg.sv
// Shared definitions for the radix-2 restoring divider: operand width,
// iteration count, FSM state encoding and the divide-by-zero quotient.
package divider_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division step: shift {partial remainder,
// dividend} left by one, subtract the divisor when it fits, and shift the
// resulting quotient bit into the LSB of the dividend register.
module divider_step
    import divider_pkg::*;
(
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] dvd_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] dvd_out
);

    // One extra bit above the 33-bit partial remainder turns the compare
    // into the sign of a single subtraction.
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic             take;

    // Shift, trial-subtract, and restore when the divisor does not fit
    always_comb begin
        shifted = {rem_in, dvd_in[WIDTH-1]};
        diff    = shifted - {2'b00, divisor};
        take    = ~diff[WIDTH+1];
        rem_out = take ? diff[WIDTH:0] : shifted[WIDTH:0];
        dvd_out = {dvd_in[WIDTH-2:0], take};
    end

endmodule

// File: rtl/divider.sv
// Free-running unsigned 32-bit radix-2 restoring divider. One result every
// 34 cycles: LOAD (1) -> CALC (32) -> DONE (1). The rst port is active-low
// with asynchronous assertion and a two-flop synchronised release.
// Optional feature: define DIVIDER_REMAINDER_EN to add the remainder port.
module divider
    import divider_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             done,
    output logic             div_by_zero
`ifdef DIVIDER_REMAINDER_EN
    ,
    output logic [WIDTH-1:0] remainder
`endif
);

    logic             rst_meta;
    logic             rst_n_int;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dsr_reg;
    logic [WIDTH:0]   rem_reg;

    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_dvd;

    // Reset release synchroniser: assertion passes straight through
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta  <= 1'b0;
            rst_n_int <= 1'b0;
        end else begin
            rst_meta  <= 1'b1;
            rst_n_int <= rst_meta;
        end
    end

    divider_step u_step (
        .rem_in  (rem_reg),
        .dvd_in  (dvd_reg),
        .divisor (dsr_reg),
        .rem_out (step_rem),
        .dvd_out (step_dvd)
    );

    // Sequencing FSM, datapath registers and registered result outputs
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state       <= LOAD;
            cnt         <= '0;
            dvd_reg     <= '0;
            dsr_reg     <= '0;
            rem_reg     <= '0;
            quotient    <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef DIVIDER_REMAINDER_EN
            remainder   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                LOAD: begin
                    dvd_reg <= dividend;
                    dsr_reg <= divisor;
                    rem_reg <= '0;
                    cnt     <= '0;
                    state   <= CALC;
                end
                CALC: begin
                    dvd_reg <= step_dvd;
                    rem_reg <= step_rem;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(ITER - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // dvd_reg now holds the quotient bits; a zero divisor is
                    // forced to the all-ones code regardless of the datapath.
                    quotient    <= (dsr_reg == '0) ? DIV0_QUOTIENT : dvd_reg;
                    div_by_zero <= (dsr_reg == '0);
`ifdef DIVIDER_REMAINDER_EN
                    remainder   <= rem_reg[WIDTH-1:0];
`endif
                    done        <= 1'b1;
                    state       <= LOAD;
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Randomised scoreboard bench for the divider. Expected results come from
// plain integer division; a monitor pops them on every done pulse and also
// checks pulse spacing and that quotient holds between pulses.
module tb_divider;

    localparam int PASS_CYCLES  = 34;
    // Two release-synchroniser edges, then one full LOAD/CALC/DONE pass
    localparam int RST_TO_DONE  = 2 + PASS_CYCLES;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic        done;
    logic        div_by_zero;
`ifdef DIVIDER_REMAINDER_EN
    logic [31:0] remainder;
`endif

    exp_t        sb[$];
    int          checks;
    int          fails;

    logic [31:0] last_q;
    int          gap;
    bit          gap_valid;

    divider dut (
        .clk         (clk),
        .rst         (rst),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .done        (done),
        .div_by_zero (div_by_zero)
`ifdef DIVIDER_REMAINDER_EN
        ,
        .remainder   (remainder)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (b == 0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply operands just before a LOAD edge and record what must come out
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        dividend = a;
        divisor  = b;
        sb.push_back(model(a, b));
    endtask

    // Count rising edges until done is seen (sampled 1 time unit after the edge)
    task automatic wait_done(output int n);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (done === 1'b1) return;
        end
        checks++;
        fails++;
        $display("FAIL wait_done: no done within %0d cycles", n);
    endtask

    // Monitor: compare each done against the scoreboard, check spacing and hold
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            last_q    = 32'h0;
            gap       = 0;
            gap_valid = 1'b0;
        end else begin
            gap++;
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_done: got quotient 0x%08h with empty scoreboard", quotient);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("quotient", quotient, e.q);
                    check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.z});
`ifdef DIVIDER_REMAINDER_EN
                    check("remainder", remainder, e.r);
`endif
                end
                if (gap_valid) check("done_spacing", gap, PASS_CYCLES);
                gap       = 0;
                gap_valid = 1'b1;
                last_q    = quotient;
            end else begin
                check("quotient_hold", quotient, last_q);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] a;
        logic [31:0] b;

        checks   = 0;
        fails    = 0;
        rst      = 1'b0;
        dividend = 32'd1000;
        divisor  = 32'd10;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_quotient", quotient, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_div_by_zero", {31'b0, div_by_zero}, 32'h0);
`ifdef DIVIDER_REMAINDER_EN
        check("rst_remainder", remainder, 32'h0);
`endif

        // First division after release: 1000 / 10
        issue(32'd1000, 32'd10);
        @(negedge clk);
        rst = 1'b1;
        wait_done(n);
        check("first_latency", n, RST_TO_DONE);

        // Held operands give the same result on consecutive passes
        for (int i = 0; i < 3; i++) begin
            issue(32'd63, 32'd7);
            wait_done(n);
        end

        // Boundary operands
        issue(32'h1234_5678, 32'h0);
        wait_done(n);
        issue(32'hFFFF_FFFF, 32'h1);
        wait_done(n);
        issue(32'd5, 32'd9);
        wait_done(n);

        // Operands changed mid-CALC must not disturb the in-flight result
        issue(32'd1000, 32'd10);
        repeat (10) @(posedge clk);
        #1;
        dividend = 32'd63;
        divisor  = 32'd7;
        wait_done(n);
        sb.push_back(model(32'd63, 32'd7));
        wait_done(n);

        // Random operands with junk driven during every CALC phase
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'h0;
                1: b = $urandom_range(1, 255);
                2: begin
                    a = $urandom_range(0, 1000);
                    b = 32'h1000 + $urandom_range(0, 100);
                end
                default: b = $urandom;
            endcase
            issue(a, b);
            repeat (3) @(posedge clk);
            #1;
            dividend = $urandom;
            divisor  = $urandom;
            wait_done(n);
        end

        // Reset 50 ns into CALC aborts the division at once
        issue(32'd1000, 32'd10);
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("abort_quotient", quotient, 32'h0);
        check("abort_done", {31'b0, done}, 32'h0);
        check("abort_div_by_zero", {31'b0, div_by_zero}, 32'h0);
        sb.delete();
        repeat (2) @(negedge clk);
        issue(32'd200, 32'd7);
        #1;
        rst = 1'b1;
        wait_done(n);
        check("restart_latency", n, RST_TO_DONE);
        @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
